disp_sched: RTL and testbench
=============================

Name: disp_sched

Overview:
- Controller that sequences the serial display driver and shares it between two sources.
- Source 1 is the calculator digit word; source 2 is a one-shot status/message word, e.g. "Err", "OFL".
- Generates periodic and event-driven load strobes, waits for the driver's transfer-done handshake and enforces a message hold time.
- Sits between rpn_stack/keyboard and serial, replacing the free-running digit-clock load strobe.

Parameters:
- REFRESH_CYC, 2048: clk cycles between periodic refresh loads (min 16).
- MSG_HOLD_CYC, 4096: clk cycles a message owns the display after acceptance.
- TIMEOUT_CYC, 256: max clk cycles to wait for tran_done after a load.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- calc_digits  in  32  calculator display word, 8 BCD/segment nibbles, MS nibble = leftmost digit.
- calc_valid  in  1  1-cycle pulse: calc_digits has changed.
- msg_req  in  1  level request to show msg_digits.
- msg_digits  in  32  message word; sampled in the msg_ack cycle.
- msg_ack  out  1  1-cycle pulse: message accepted.
- load_data  out  1  1-cycle load strobe to the serial driver.
- data_out  out  32  word presented to the serial driver.
- tran_done  in  1  serial driver has finished shifting, level or pulse.
- src_msg  out  1  1 = display currently owned by the message.
- busy  out  1  1 while in LOAD or WAIT.
- err_timeout  out  1  sticky; set on tran_done timeout, cleared only by rst.

Behaviour:
- Reset values: load_data=0, msg_ack=0, data_out=0, src_msg=0, busy=0, err_timeout=0; state=IDLE; refresh counter=0; hold counter=0; internal calc latch=0; pending-update flag=0.
- Calc latch: captures calc_digits on every calc_valid, in any state. The calc_valid cycle sets the pending flag.
- Message acceptance:
  - Occurs in any state when msg_req=1 and msg_ack was 0 in the previous cycle.
  - Pulses msg_ack, latches msg_digits, sets src_msg=1, loads the hold counter with MSG_HOLD_CYC-1 and sets pending.
  - A requester that holds msg_req high re-acks every other cycle, so requesters must drop msg_req on ack.
- Hold expiry: the hold counter decrements each cycle while src_msg=1. On reaching 0, src_msg clears and pending is set, so the calc word is redisplayed immediately.
- Source selection: data_out word = message latch if src_msg, else calc latch. It is captured into data_out on entry to LOAD.
- FSM states: IDLE, LOAD, WAIT, GAP.
  - IDLE -> LOAD when pending=1 or the refresh counter reaches REFRESH_CYC-1. Clears pending and the refresh counter.
  - LOAD: load_data=1 for exactly this cycle; data_out is valid from this cycle until the next LOAD. Always -> WAIT.
  - WAIT: timeout counter runs from 0.
    - tran_done=1 -> GAP.
    - Counter reaching TIMEOUT_CYC-1 -> set err_timeout and go to GAP. The retry happens at the next refresh or pending event.
  - GAP: 1 cycle, waits for tran_done to deassert, then -> IDLE.
- tran_done is ignored outside WAIT.
- The refresh counter runs in all states and wraps at REFRESH_CYC-1.
- Simultaneous events:
  - msg_req and calc_valid in the same cycle: the message wins ownership and the calc word is still latched.
  - An event arriving during LOAD/WAIT/GAP only sets pending. It is serviced on the next IDLE, so there is never more than one outstanding load.
  - A new message during hold restarts the hold with the new word.
- Reset mid-transfer: returns to IDLE with no load_data glitch. The first load after reset happens at REFRESH_CYC cycles, or earlier on an event.
- Latency: event in cycle N (state IDLE) -> load_data in cycle N+2, allowing one cycle for pending to register.

Optional Feature:
- Macro: DISP_SCHED_LEADING_ZERO_BLANK_EN.
- Defined: in the calc source only, leading nibbles equal to 0, scanning from the MS nibble, are replaced by 4'hF (blank code). The LS nibble is never blanked, so all-zero displays "       0". Message words pass unmodified.
- Undefined: calc word passes through unchanged; no blanking logic is synthesized.

Decomposition:
- Package disp_pkg holds:
  - state encoding (IDLE, LOAD, WAIT, GAP);
  - NUM_DIGITS=8 and NIBBLE_W=4;
  - BLANK_NIBBLE=4'hF.
- One natural sub-module: lz_blank, a combinational leading-zero blanker instantiated only under the macro.
- Counters and the FSM stay in disp_sched.

Test Plan:
- Reset, then idle for 2*REFRESH_CYC with tran_done echoed 3 cycles after load -> exactly 2 load_data pulses, REFRESH_CYC apart; data_out=32'h0.
- calc_valid with calc_digits=32'h0000_1234 in IDLE -> load_data 2 cycles later, data_out=32'h0000_1234. With the macro: 32'hFFFF_1234; calc_digits=0 gives 32'hFFFF_FFF0.
- msg_req with msg_digits=32'hE0FF_FFFF, same cycle as calc_valid 32'h42 -> msg_ack 1 cycle, data_out=32'hE0FF_FFFF, src_msg=1. After MSG_HOLD_CYC: src_msg=0 and a load with 32'h42.
- tran_done held 0 -> err_timeout=1 after TIMEOUT_CYC cycles in WAIT, and it stays 1. A later tran_done echo makes refreshes resume; only rst clears err_timeout.
- calc_valid pulses 3 times during WAIT (values 1, 2, 3) -> a single follow-up load with data_out=32'h3, and no load_data while busy=1.
- rst asserted during WAIT -> next cycle: all outputs at reset values and state IDLE; no load_data until the refresh period or a new event.

Source files
------------

// File: rtl/disp_pkg.sv
// ============================================================================
//  Module      : disp_pkg
//  Description : Shared constants and state encoding for the display scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int NIBBLE_W   = 4;
    localparam int WORD_W     = NUM_DIGITS * NIBBLE_W;

    localparam logic [NIBBLE_W-1:0] BLANK_NIBBLE = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/disp_sched_if.sv
// ============================================================================
//  Module      : disp_sched_if
//  Description : Source, message and serial-driver signals of the scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface disp_sched_if;

    logic [disp_pkg::WORD_W-1:0] calc_digits;
    logic                        calc_valid;
    logic                        msg_req;
    logic [disp_pkg::WORD_W-1:0] msg_digits;
    logic                        msg_ack;
    logic                        load_data;
    logic [disp_pkg::WORD_W-1:0] data_out;
    logic                        tran_done;
    logic                        src_msg;
    logic                        busy;
    logic                        err_timeout;

    // master: the scheduler itself
    modport master (
        input  calc_digits, calc_valid, msg_req, msg_digits, tran_done,
        output msg_ack, load_data, data_out, src_msg, busy, err_timeout
    );

    // slave: sources and serial driver around the scheduler
    modport slave (
        output calc_digits, calc_valid, msg_req, msg_digits, tran_done,
        input  msg_ack, load_data, data_out, src_msg, busy, err_timeout
    );

endinterface

`default_nettype wire

// File: rtl/lz_blank.sv
// ============================================================================
//  Module      : lz_blank
//  Description : Replaces leading zero nibbles with the blank code; the least
//                significant nibble is always kept.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lz_blank
    import disp_pkg::*;
(
    input  wire logic [WORD_W-1:0] i_digits,
    output      logic [WORD_W-1:0] o_digits
);

    logic w_leading;

    always_comb begin
        o_digits  = i_digits;
        w_leading = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            if (w_leading && (i_digits[k*NIBBLE_W +: NIBBLE_W] == '0)) begin
                o_digits[k*NIBBLE_W +: NIBBLE_W] = BLANK_NIBBLE;
            end else begin
                w_leading = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/disp_sched.sv
// ============================================================================
//  Module      : disp_sched
//  Description : Shares the serial display driver between the calculator word
//                and one-shot messages; optional leading-zero blanking of the
//                calculator word under DISP_SCHED_LEADING_ZERO_BLANK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_sched
    import disp_pkg::*;
#(
    parameter int REFRESH_CYC  = 2048,
    parameter int MSG_HOLD_CYC = 4096,
    parameter int TIMEOUT_CYC  = 256
) (
    input  wire logic    clk,
    input  wire logic    rst,
    disp_sched_if.master bus
);

    localparam int C_RF_W = $clog2(REFRESH_CYC + 1);
    localparam int C_HD_W = $clog2(MSG_HOLD_CYC + 1);
    localparam int C_TO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [C_RF_W-1:0] c_refresh_last = C_RF_W'(REFRESH_CYC - 1);
    localparam logic [C_HD_W-1:0] c_hold_last    = C_HD_W'(MSG_HOLD_CYC - 1);
    localparam logic [C_TO_W-1:0] c_timeout_last = C_TO_W'(TIMEOUT_CYC - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [C_RF_W-1:0]   r_refresh_cnt;
    logic [C_HD_W-1:0]   r_hold_cnt;
    logic [C_TO_W-1:0]   r_timeout_cnt;
    logic [WORD_W-1:0]   r_calc_latch;
    logic [WORD_W-1:0]   r_msg_latch;
    logic [WORD_W-1:0]   r_data_out;
    logic                r_pending;
    logic                r_src_msg;
    logic                r_msg_ack_q;
    logic                r_err_timeout;

    logic                w_msg_accept;
    logic                w_refresh_hit;
    logic                w_timeout_hit;
    logic                w_hold_expire;
    logic                w_start;
    logic                w_set_pending;
    logic [WORD_W-1:0]   w_calc_word;
    logic [WORD_W-1:0]   w_sel_word;

`ifdef DISP_SCHED_LEADING_ZERO_BLANK_EN
    lz_blank u_lz_blank (
        .i_digits (r_calc_latch),
        .o_digits (w_calc_word)
    );
`else
    assign w_calc_word = r_calc_latch;
`endif

    // Ack is combinational so msg_digits is sampled in the ack cycle itself.
    assign w_msg_accept  = bus.msg_req & ~r_msg_ack_q & ~rst;
    assign w_refresh_hit = (r_refresh_cnt == c_refresh_last);
    assign w_timeout_hit = (r_timeout_cnt == c_timeout_last);
    assign w_hold_expire = r_src_msg & (r_hold_cnt == '0) & ~w_msg_accept;
    assign w_start       = (r_state == IDLE) & (r_pending | w_refresh_hit);
    assign w_set_pending = bus.calc_valid | w_msg_accept | w_hold_expire;
    assign w_sel_word    = r_src_msg ? r_msg_latch : w_calc_word;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_start) w_state_nxt = LOAD;
            LOAD: w_state_nxt = WAIT;
            WAIT: if (bus.tran_done || w_timeout_hit) w_state_nxt = GAP;
            GAP:  if (!bus.tran_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_refresh_cnt <= '0;
            r_hold_cnt    <= '0;
            r_timeout_cnt <= '0;
            r_calc_latch  <= '0;
            r_msg_latch   <= '0;
            r_data_out    <= '0;
            r_pending     <= 1'b0;
            r_src_msg     <= 1'b0;
            r_msg_ack_q   <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_msg_ack_q <= w_msg_accept;

            if (w_start || w_refresh_hit) begin
                r_refresh_cnt <= '0;
            end else begin
                r_refresh_cnt <= r_refresh_cnt + 1'b1;
            end

            if (r_state != WAIT) begin
                r_timeout_cnt <= '0;
            end else begin
                r_timeout_cnt <= r_timeout_cnt + 1'b1;
            end

            if ((r_state == WAIT) && !bus.tran_done && w_timeout_hit) begin
                r_err_timeout <= 1'b1;
            end

            if (bus.calc_valid) begin
                r_calc_latch <= bus.calc_digits;
            end

            if (w_msg_accept) begin
                r_msg_latch <= bus.msg_digits;
                r_src_msg   <= 1'b1;
                r_hold_cnt  <= c_hold_last;
            end else if (w_hold_expire) begin
                r_src_msg   <= 1'b0;
            end else if (r_src_msg) begin
                r_hold_cnt  <= r_hold_cnt - 1'b1;
            end

            // A new event wins over the clear so it is never lost.
            if (w_set_pending) begin
                r_pending <= 1'b1;
            end else if (w_start) begin
                r_pending <= 1'b0;
            end

            if (w_start) begin
                r_data_out <= w_sel_word;
            end
        end
    end

    assign bus.msg_ack     = w_msg_accept;
    assign bus.load_data   = (r_state == LOAD);
    assign bus.busy        = (r_state == LOAD) || (r_state == WAIT);
    assign bus.data_out    = r_data_out;
    assign bus.src_msg     = r_src_msg;
    assign bus.err_timeout = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_disp_sched.sv
// ============================================================================
//  Module      : tb_disp_sched
//  Description : Directed self-checking bench for disp_sched (small periods).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_disp_sched;

    localparam int REFRESH = 64;
    localparam int HOLD    = 128;
    localparam int TMO     = 16;

`ifdef DISP_SCHED_LEADING_ZERO_BLANK_EN
    localparam logic [31:0] E_ZERO = 32'hFFFF_FFF0;
    localparam logic [31:0] E_1234 = 32'hFFFF_1234;
    localparam logic [31:0] E_42   = 32'hFFFF_FF42;
    localparam logic [31:0] E_88   = 32'hFFFF_FF88;
    localparam logic [31:0] E_3    = 32'hFFFF_FFF3;
`else
    localparam logic [31:0] E_ZERO = 32'h0000_0000;
    localparam logic [31:0] E_1234 = 32'h0000_1234;
    localparam logic [31:0] E_42   = 32'h0000_0042;
    localparam logic [31:0] E_88   = 32'h0000_0088;
    localparam logic [31:0] E_3    = 32'h0000_0003;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic echo_en = 1'b0;
    int   tests = 0;
    int   fails = 0;

    disp_sched_if dif ();

    disp_sched #(
        .REFRESH_CYC  (REFRESH),
        .MSG_HOLD_CYC (HOLD),
        .TIMEOUT_CYC  (TMO)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.master)
    );

    always #5 clk = ~clk;

    // Serial driver model: answers each load with a 1-cycle done 3 cycles later.
    initial begin
        dif.tran_done = 1'b0;
        forever begin
            @(negedge clk);
            if (echo_en && dif.load_data) begin
                repeat (3) @(negedge clk);
                dif.tran_done = 1'b1;
                @(negedge clk);
                dif.tran_done = 1'b0;
            end
        end
    end

    task automatic wait_load(input int max_cyc, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < max_cyc) begin
            @(negedge clk);
            n++;
            if (dif.load_data) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_calc(input logic [31:0] val);
        dif.calc_digits = val;
        dif.calc_valid  = 1'b1;
        @(negedge clk);
        dif.calc_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (dif.load_data !== 1'b0)   begin fails++; $display("FAIL reset_load_data: got %b want 0", dif.load_data); end
        tests++; if (dif.msg_ack !== 1'b0)     begin fails++; $display("FAIL reset_msg_ack: got %b want 0", dif.msg_ack); end
        tests++; if (dif.data_out !== 32'h0)   begin fails++; $display("FAIL reset_data_out: got %h want 0", dif.data_out); end
        tests++; if (dif.src_msg !== 1'b0)     begin fails++; $display("FAIL reset_src_msg: got %b want 0", dif.src_msg); end
        tests++; if (dif.busy !== 1'b0)        begin fails++; $display("FAIL reset_busy: got %b want 0", dif.busy); end
        tests++; if (dif.err_timeout !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", dif.err_timeout); end
    endtask

    task automatic test_refresh();
        int n; bit ok;
        echo_en = 1'b1;
        wait_load(200, n, ok);
        tests++; if (!ok || n !== REFRESH) begin fails++; $display("FAIL refresh_first: got %0d cycles want %0d", n, REFRESH); end
        tests++; if (dif.data_out !== E_ZERO) begin fails++; $display("FAIL refresh_first_data: got %h want %h", dif.data_out, E_ZERO); end
        wait_load(200, n, ok);
        tests++; if (!ok || n !== REFRESH) begin fails++; $display("FAIL refresh_second: got %0d cycles want %0d", n, REFRESH); end
        tests++; if (dif.data_out !== E_ZERO) begin fails++; $display("FAIL refresh_second_data: got %h want %h", dif.data_out, E_ZERO); end
    endtask

    task automatic test_calc();
        int n; bit ok;
        repeat (8) @(negedge clk);
        pulse_calc(32'h0000_1234);
        wait_load(20, n, ok);
        tests++; if (!ok || n !== 1) begin fails++; $display("FAIL calc_latency: got %0d want 1", n); end
        tests++; if (dif.data_out !== E_1234) begin fails++; $display("FAIL calc_data: got %h want %h", dif.data_out, E_1234); end
        repeat (8) @(negedge clk);
        pulse_calc(32'h0000_0000);
        wait_load(20, n, ok);
        tests++; if (!ok || n !== 1) begin fails++; $display("FAIL calc_zero_latency: got %0d want 1", n); end
        tests++; if (dif.data_out !== E_ZERO) begin fails++; $display("FAIL calc_zero_data: got %h want %h", dif.data_out, E_ZERO); end
    endtask

    task automatic test_msg();
        int n; bit ok;
        repeat (8) @(negedge clk);
        dif.msg_digits  = 32'hE0FF_FFFF;
        dif.msg_req     = 1'b1;
        dif.calc_digits = 32'h0000_0042;
        dif.calc_valid  = 1'b1;
        #1;
        tests++; if (dif.msg_ack !== 1'b1) begin fails++; $display("FAIL msg_ack_pulse: got %b want 1", dif.msg_ack); end
        @(negedge clk);
        #1;
        tests++; if (dif.msg_ack !== 1'b0) begin fails++; $display("FAIL msg_ack_second: got %b want 0", dif.msg_ack); end
        tests++; if (dif.src_msg !== 1'b1) begin fails++; $display("FAIL msg_src_set: got %b want 1", dif.src_msg); end
        dif.msg_req    = 1'b0;
        dif.calc_valid = 1'b0;
        wait_load(20, n, ok);
        tests++; if (!ok || n !== 1) begin fails++; $display("FAIL msg_latency: got %0d want 1", n); end
        tests++; if (dif.data_out !== 32'hE0FF_FFFF) begin fails++; $display("FAIL msg_data: got %h want e0ffffff", dif.data_out); end
        wait_load(200, n, ok);
        tests++; if (!ok || n !== REFRESH || dif.data_out !== 32'hE0FF_FFFF) begin
            fails++; $display("FAIL msg_hold_refresh: got %0d cycles data %h want %0d e0ffffff", n, dif.data_out, REFRESH);
        end
        wait_load(200, n, ok);
        tests++; if (!ok || n !== HOLD - REFRESH) begin fails++; $display("FAIL msg_expire_time: got %0d want %0d", n, HOLD - REFRESH); end
        tests++; if (dif.data_out !== E_42) begin fails++; $display("FAIL msg_expire_data: got %h want %h", dif.data_out, E_42); end
        tests++; if (dif.src_msg !== 1'b0) begin fails++; $display("FAIL msg_src_clear: got %b want 0", dif.src_msg); end
    endtask

    task automatic test_timeout();
        int n; bit ok;
        repeat (8) @(negedge clk);
        echo_en = 1'b0;
        pulse_calc(32'h0000_0077);
        wait_load(20, n, ok);
        tests++; if (!ok || n !== 1) begin fails++; $display("FAIL tmo_load: got %0d want 1", n); end
        repeat (TMO) @(negedge clk);
        tests++; if (dif.err_timeout !== 1'b0 || dif.busy !== 1'b1) begin
            fails++; $display("FAIL tmo_early: err %b busy %b want 0 1", dif.err_timeout, dif.busy);
        end
        @(negedge clk);
        tests++; if (dif.err_timeout !== 1'b1 || dif.busy !== 1'b0) begin
            fails++; $display("FAIL tmo_set: err %b busy %b want 1 0", dif.err_timeout, dif.busy);
        end
        repeat (3) @(negedge clk);
        echo_en = 1'b1;
        pulse_calc(32'h0000_0088);
        wait_load(20, n, ok);
        tests++; if (!ok || n !== 1 || dif.data_out !== E_88) begin
            fails++; $display("FAIL tmo_retry: got %0d cycles data %h want 1 %h", n, dif.data_out, E_88);
        end
        wait_load(200, n, ok);
        tests++; if (!ok || n !== REFRESH) begin fails++; $display("FAIL tmo_refresh_resume: got %0d want %0d", n, REFRESH); end
        tests++; if (dif.err_timeout !== 1'b1) begin fails++; $display("FAIL tmo_sticky: got %b want 1", dif.err_timeout); end
    endtask

    task automatic test_back_to_back();
        int n; bit ok; int extra;
        repeat (8) @(negedge clk);
        pulse_calc(32'h0000_0010);
        wait_load(20, n, ok);
        tests++; if (!ok || n !== 1) begin fails++; $display("FAIL b2b_first: got %0d want 1", n); end
        @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
            dif.calc_digits = 32'(i);
            dif.calc_valid  = 1'b1;
            @(negedge clk);
            tests++; if (dif.load_data !== 1'b0) begin fails++; $display("FAIL b2b_no_load_busy_%0d: got %b want 0", i, dif.load_data); end
        end
        dif.calc_valid = 1'b0;
        wait_load(20, n, ok);
        tests++; if (!ok || n !== 2) begin fails++; $display("FAIL b2b_followup: got %0d want 2", n); end
        tests++; if (dif.data_out !== E_3) begin fails++; $display("FAIL b2b_data: got %h want %h", dif.data_out, E_3); end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (dif.load_data) extra++;
        end
        tests++; if (extra !== 0) begin fails++; $display("FAIL b2b_single: got %0d extra loads want 0", extra); end
    endtask

    task automatic test_rst_mid();
        int n; bit ok;
        repeat (8) @(negedge clk);
        echo_en = 1'b0;
        pulse_calc(32'h0000_0055);
        wait_load(20, n, ok);
        tests++; if (!ok || n !== 1) begin fails++; $display("FAIL rst_mid_load: got %0d want 1", n); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        tests++; if (dif.load_data !== 1'b0 || dif.busy !== 1'b0) begin
            fails++; $display("FAIL rst_mid_state: load %b busy %b want 0 0", dif.load_data, dif.busy);
        end
        tests++; if (dif.data_out !== 32'h0) begin fails++; $display("FAIL rst_mid_data: got %h want 0", dif.data_out); end
        tests++; if (dif.err_timeout !== 1'b0) begin fails++; $display("FAIL rst_mid_err: got %b want 0", dif.err_timeout); end
        tests++; if (dif.src_msg !== 1'b0 || dif.msg_ack !== 1'b0) begin
            fails++; $display("FAIL rst_mid_msg: src %b ack %b want 0 0", dif.src_msg, dif.msg_ack);
        end
        rst     = 1'b0;
        echo_en = 1'b1;
        wait_load(200, n, ok);
        tests++; if (!ok || n !== REFRESH) begin fails++; $display("FAIL rst_mid_first_load: got %0d want %0d", n, REFRESH); end
        tests++; if (dif.data_out !== E_ZERO) begin fails++; $display("FAIL rst_mid_latch: got %h want %h", dif.data_out, E_ZERO); end
    endtask

    initial begin
        dif.calc_digits = '0;
        dif.calc_valid  = 1'b0;
        dif.msg_req     = 1'b0;
        dif.msg_digits  = '0;
        test_reset();
        test_refresh();
        test_calc();
        test_msg();
        test_timeout();
        test_back_to_back();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
